// File: rtl/dmi_dr_ctrl.sv
// JTAG data-register controller for the dtmcs and dmi registers. It turns each
// dmi update into one Debug Module request and returns the response at the next capture.
module dmi_dr_ctrl #(
    parameter int unsigned ABITS = 7,
    parameter int unsigned IDLE  = 1
) (
    input  logic             tck_i,
    input  logic             rst_i,
    input  logic             dmi_clear_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             tdi_i,
    input  logic             dtmcs_select_i,
    output logic             dtmcs_tdo_o,
    input  logic             dmi_select_i,
    output logic             dmi_tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [1:0]       dmi_req_op_o,
    output logic [31:0]      dmi_req_data_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic [1:0]       dmi_resp_resp_i,
    output logic             dmi_hardreset_o
);
    localparam int unsigned W = ABITS + 34;
    localparam logic [2:0] IDLE_HINT   = 3'(IDLE);
    localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_READ,
        ST_WRITE,
        ST_WAIT_WRITE
    } state_e;

    state_e           state_q;
    logic [1:0]       error_q;
    logic [ABITS-1:0] addr_q;
    logic [31:0]      data_q;
    logic [31:0]      dtmcs_sr_q;
    logic [W-1:0]     dmi_sr_q;
    logic             req_valid_q;
    logic [1:0]       req_op_q;
    logic             resp_ready_q;
    logic             hardreset_q;

    logic             dmi_sel;
    logic             busy;
    logic [31:0]      dtmcs_value;
    logic [W-1:0]     dmi_capture;
    logic [1:0]       upd_op;

    // dtmcs has priority when both registers are selected
    assign dmi_sel     = dmi_select_i & ~dtmcs_select_i;
    assign busy        = (state_q != ST_IDLE);
    assign dtmcs_value = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, error_q, ABITS_FIELD, 4'd1};
    assign dmi_capture = {addr_q, data_q, (busy ? 2'b11 : error_q)};
    assign upd_op      = dmi_sr_q[1:0];

    always_ff @(posedge tck_i) begin
        if (rst_i || dmi_clear_i) begin
            state_q      <= ST_IDLE;
            error_q      <= 2'd0;
            addr_q       <= '0;
            data_q       <= '0;
            dtmcs_sr_q   <= '0;
            dmi_sr_q     <= '0;
            req_valid_q  <= 1'b0;
            req_op_q     <= 2'd0;
            resp_ready_q <= 1'b0;
            hardreset_q  <= 1'b0;
        end else begin
            hardreset_q <= 1'b0;

            case (state_q)
                ST_READ: if (dmi_req_ready_i) begin
                    state_q      <= ST_WAIT_READ;
                    req_valid_q  <= 1'b0;
                    req_op_q     <= 2'd0;
                    resp_ready_q <= 1'b1;
                end
                ST_WRITE: if (dmi_req_ready_i) begin
                    state_q      <= ST_WAIT_WRITE;
                    req_valid_q  <= 1'b0;
                    req_op_q     <= 2'd0;
                    resp_ready_q <= 1'b1;
                end
                ST_WAIT_READ, ST_WAIT_WRITE: if (dmi_resp_valid_i) begin
                    if (state_q == ST_WAIT_READ) begin
                        data_q <= dmi_resp_data_i;
                    end
                    // a pending busy error is never downgraded to failed
                    if (dmi_resp_resp_i != 2'd0 && error_q == 2'd0) begin
                        error_q <= 2'd2;
                    end
                    state_q      <= ST_IDLE;
                    resp_ready_q <= 1'b0;
                end
                default: ;
            endcase

            if (dtmcs_select_i) begin
                if (update_i) begin
                    if (dtmcs_sr_q[16] || dtmcs_sr_q[17]) begin
                        error_q <= 2'd0;
                    end
                    if (dtmcs_sr_q[17]) begin
                        state_q      <= ST_IDLE;
                        req_valid_q  <= 1'b0;
                        req_op_q     <= 2'd0;
                        resp_ready_q <= 1'b0;
                        hardreset_q  <= 1'b1;
                    end
                end else if (capture_i) begin
                    dtmcs_sr_q <= dtmcs_value;
                end else if (shift_i) begin
                    dtmcs_sr_q <= {tdi_i, dtmcs_sr_q[31:1]};
                end
            end

            if (dmi_sel) begin
                if (update_i) begin
                    if (busy) begin
                        error_q <= 2'd3;
                    end else if (error_q == 2'd0) begin
                        addr_q <= dmi_sr_q[W-1:34];
                        if (upd_op == 2'd1) begin
                            state_q     <= ST_READ;
                            req_valid_q <= 1'b1;
                            req_op_q    <= 2'd1;
                        end else if (upd_op == 2'd2) begin
                            data_q      <= dmi_sr_q[33:2];
                            state_q     <= ST_WRITE;
                            req_valid_q <= 1'b1;
                            req_op_q    <= 2'd2;
                        end
                    end
                end else if (capture_i) begin
                    dmi_sr_q <= dmi_capture;
                    if (busy) begin
                        error_q <= 2'd3;
                    end
                end else if (shift_i) begin
                    dmi_sr_q <= {tdi_i, dmi_sr_q[W-1:1]};
                end
            end
        end
    end

    assign dtmcs_tdo_o      = dtmcs_sr_q[0];
    assign dmi_tdo_o        = dmi_sr_q[0];
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_dmi_dr_ctrl.sv
// Bench for dmi_dr_ctrl: directed TAP scans, then random dmi/dtmcs traffic
// against a transaction-level model and a simple Debug Module responder.
module tb_dmi_dr_ctrl;
    logic        tck_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        dmi_clear_i = 1'b0;
    logic        capture_i = 1'b0;
    logic        shift_i = 1'b0;
    logic        update_i = 1'b0;
    logic        tdi_i = 1'b0;
    logic        dtmcs_select_i = 1'b0;
    logic        dmi_select_i = 1'b0;
    logic        dtmcs_tdo_o;
    logic        dmi_tdo_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [6:0]  dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0]  dmi_resp_resp_i;
    logic        dmi_hardreset_o;

    // DM side is driven either directly by the directed steps or by the responder
    logic        auto_dm = 1'b0;
    logic        d_ready = 1'b0, d_rvalid = 1'b0;
    logic [31:0] d_rdata = '0;
    logic [1:0]  d_rresp = '0;
    logic        a_ready = 1'b0, a_rvalid = 1'b0;
    logic [31:0] a_rdata = '0;
    logic [1:0]  a_rresp = '0;
    logic [1:0]  dm_resp_code = '0;
    logic [31:0] dm_mem [0:127];
    logic [40:0] exp_req [$];

    assign dmi_req_ready_i  = auto_dm ? a_ready  : d_ready;
    assign dmi_resp_valid_i = auto_dm ? a_rvalid : d_rvalid;
    assign dmi_resp_data_i  = auto_dm ? a_rdata  : d_rdata;
    assign dmi_resp_resp_i  = auto_dm ? a_rresp  : d_rresp;

    int n_cmp = 0;
    int n_err = 0;

    dmi_dr_ctrl dut (
        .tck_i(tck_i), .rst_i(rst_i), .dmi_clear_i(dmi_clear_i),
        .capture_i(capture_i), .shift_i(shift_i), .update_i(update_i), .tdi_i(tdi_i),
        .dtmcs_select_i(dtmcs_select_i), .dtmcs_tdo_o(dtmcs_tdo_o),
        .dmi_select_i(dmi_select_i), .dmi_tdo_o(dmi_tdo_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
        .dmi_req_data_o(dmi_req_data_o), .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
        .dmi_resp_resp_i(dmi_resp_resp_i), .dmi_hardreset_o(dmi_hardreset_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    function automatic logic [63:0] dtmcs_exp(input logic [1:0] err);
        return 64'h1071 | (64'(err) << 10);
    endfunction

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    // capture, len shifts, update; dout holds the bits seen on tdo, LSB first
    task automatic scan(input logic sel_t, input logic sel_d, input logic [63:0] din,
                        input int len, output logic [63:0] dout);
        dtmcs_select_i = sel_t;
        dmi_select_i   = sel_d;
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        dout = '0;
        shift_i = 1'b1;
        for (int i = 0; i < len; i++) begin
            dout[i] = sel_t ? dtmcs_tdo_o : dmi_tdo_o;
            tdi_i = din[i];
            tick();
        end
        shift_i  = 1'b0;
        tdi_i    = 1'b0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        dtmcs_select_i = 1'b0;
        dmi_select_i   = 1'b0;
    endtask

    task automatic dm_respond(input logic [31:0] data, input logic [1:0] resp);
        d_rvalid = 1'b1; d_rdata = data; d_rresp = resp;
        tick();
        d_rvalid = 1'b0; d_rresp = 2'd0;
    endtask

    task automatic dm_accept();
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
    endtask

    // Debug Module responder used during the random phase
    initial begin
        logic [6:0]  r_addr;
        logic [31:0] r_data;
        logic [1:0]  r_op;
        logic [40:0] e;
        int n;
        forever begin
            @(posedge tck_i); #2;
            if (auto_dm && dmi_req_valid_o) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin @(posedge tck_i); #2; end
                r_addr = dmi_req_addr_o; r_data = dmi_req_data_o; r_op = dmi_req_op_o;
                if (exp_req.size() == 0) begin
                    check("rnd_unexpected_req", {23'b0, r_addr, r_data, r_op}, 64'h0);
                end else begin
                    e = exp_req.pop_front();
                    check("rnd_req_fields", {23'b0, r_addr, r_data, r_op}, {23'b0, e});
                end
                a_ready = 1'b1;
                @(posedge tck_i); #2;
                a_ready = 1'b0;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin @(posedge tck_i); #2; end
                a_rdata  = (r_op == 2'd1) ? dm_mem[r_addr] : $urandom;
                a_rresp  = dm_resp_code;
                a_rvalid = 1'b1;
                @(posedge tck_i); #2;
                a_rvalid = 1'b0;
                a_rresp  = 2'd0;
                if (r_op == 2'd2 && dm_resp_code == 2'd0) dm_mem[r_addr] = r_data;
            end
        end
    end

    initial begin
        logic [63:0] dout;
        logic [63:0] din;
        logic [6:0]  m_addr;
        logic [31:0] m_data;
        logic [1:0]  m_err;
        logic [6:0]  ra;
        logic [31:0] rd;
        logic [1:0]  rop;
        logic [1:0]  rcode;

        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_valid", dmi_req_valid_o, 0);
        check("rst_resp_ready", dmi_resp_ready_o, 0);
        check("rst_hardreset", dmi_hardreset_o, 0);
        check("rst_tdo", {dtmcs_tdo_o, dmi_tdo_o}, 0);

        scan(1, 0, 64'h0, 32, dout);
        check("dtmcs_reset_value", dout[31:0], 64'h0000_1071);

        // write 0x10 <- DEADBEEF with ready held low for a while
        scan(0, 1, dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, dout);
        check("wr_capture", dout, 0);
        check("wr_req", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o},
              {1'b1, 7'h10, 2'd2, 32'hDEADBEEF});
        repeat (5) tick();
        check("wr_held", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o},
              {1'b1, 7'h10, 2'd2, 32'hDEADBEEF});
        dm_accept();
        check("wr_wait", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
        dm_respond(32'h0, 2'd0);
        check("wr_done", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b00);

        // read 0x11
        scan(0, 1, dmi_word(7'h11, 32'h0, 2'd1), 41, dout);
        check("rd_capture_prev", dout, dmi_word(7'h10, 32'hDEADBEEF, 2'd0));
        check("rd_req", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o}, {1'b1, 7'h11, 2'd1});
        dm_accept();
        dm_respond(32'h12345678, 2'd0);
        scan(0, 1, dmi_word(7'h11, 32'h0, 2'd0), 41, dout);
        check("rd_result", dout, dmi_word(7'h11, 32'h12345678, 2'd0));

        // busy: capture/update while a read is outstanding
        scan(0, 1, dmi_word(7'h12, 32'h0, 2'd1), 41, dout);
        dm_accept();
        scan(0, 1, dmi_word(7'h13, 32'h0, 2'd1), 41, dout);
        check("busy_capture", dout, dmi_word(7'h12, 32'h12345678, 2'd3));
        check("busy_no_req", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
        dm_respond(32'hCAFEF00D, 2'd0);
        scan(0, 1, dmi_word(7'h15, 32'h0, 2'd1), 41, dout);
        check("busy_sticky", dout, dmi_word(7'h12, 32'hCAFEF00D, 2'd3));
        check("busy_ignored", {dmi_req_valid_o, dmi_req_addr_o}, {1'b0, 7'h12});
        scan(1, 0, 64'h1_0000, 32, dout);
        check("busy_dtmcs", dout[31:0], dtmcs_exp(2'd3));
        scan(1, 0, 64'h0, 32, dout);
        check("dmireset_clears", dout[31:0], dtmcs_exp(2'd0));
        scan(0, 1, dmi_word(7'h16, 32'h0, 2'd1), 41, dout);
        check("after_reset_capture", dout, dmi_word(7'h12, 32'hCAFEF00D, 2'd0));
        check("after_reset_req", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o}, {1'b1, 7'h16, 2'd1});
        dm_accept();
        dm_respond(32'hA5A5A5A5, 2'd0);

        // failed response
        scan(0, 1, dmi_word(7'h20, 32'h0, 2'd1), 41, dout);
        dm_accept();
        dm_respond(32'h0BADF00D, 2'd2);
        scan(1, 0, 64'h0, 32, dout);
        check("failed_dtmcs", dout[31:0], dtmcs_exp(2'd2));
        scan(0, 1, dmi_word(7'h21, 32'h1, 2'd2), 41, dout);
        check("failed_capture", dout, dmi_word(7'h20, 32'h0BADF00D, 2'd2));
        check("failed_ignored", dmi_req_valid_o, 0);
        scan(1, 0, 64'h1_0000, 32, dout);
        check("failed_dtmcs2", dout[31:0], dtmcs_exp(2'd2));
        scan(1, 0, 64'h0, 32, dout);
        check("failed_cleared", dout[31:0], dtmcs_exp(2'd0));

        // dmihardreset during WAIT_WRITE
        scan(0, 1, dmi_word(7'h30, 32'h11112222, 2'd2), 41, dout);
        check("hr_capture", dout, dmi_word(7'h20, 32'h0BADF00D, 2'd0));
        dm_accept();
        check("hr_wait", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
        scan(1, 0, 64'h2_0000, 32, dout);
        check("hr_pulse", {dmi_hardreset_o, dmi_req_valid_o, dmi_resp_ready_o}, 3'b100);
        tick();
        check("hr_pulse_end", {dmi_hardreset_o, dmi_req_valid_o, dmi_resp_ready_o}, 3'b000);
        scan(1, 0, 64'h0, 32, dout);
        check("hr_dtmcs", dout[31:0], dtmcs_exp(2'd0));

        // rst_i mid-read
        scan(0, 1, dmi_word(7'h31, 32'h0, 2'd1), 41, dout);
        check("rstmid_req", dmi_req_valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstmid_outs", {dmi_req_valid_o, dmi_resp_ready_o, dmi_hardreset_o, dtmcs_tdo_o, dmi_tdo_o}, 0);
        scan(0, 1, 64'h0, 41, dout);
        check("rstmid_cleared", dout, 0);

        // dmi_clear_i during WAIT_WRITE
        scan(0, 1, dmi_word(7'h05, 32'h55, 2'd2), 41, dout);
        dm_accept();
        dmi_clear_i = 1'b1;
        tick();
        dmi_clear_i = 1'b0;
        check("clear_outs", {dmi_req_valid_o, dmi_resp_ready_o}, 0);
        scan(0, 1, 64'h0, 41, dout);
        check("clear_regs", dout, 0);

        // both selects: only dtmcs acts
        scan(1, 1, dmi_word(7'h55, 32'h0, 2'd2), 41, dout);
        check("both_sel_tdo", dout[31:0], dtmcs_exp(2'd0));
        check("both_sel_no_req", dmi_req_valid_o, 0);
        scan(0, 1, 64'h0, 41, dout);
        check("both_sel_dmi_untouched", dout, 0);

        // random traffic against the transaction-level model
        for (int i = 0; i < 128; i++) dm_mem[i] = $urandom;
        m_addr = '0; m_data = '0; m_err = '0;
        auto_dm = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                din = {32'b0, 32'($urandom)};
                din[17] = 1'b0;
                din[16] = 1'($urandom_range(0, 1));
                scan(1, 0, din, 32, dout);
                check("rnd_dtmcs", dout[31:0], dtmcs_exp(m_err));
                if (din[16]) m_err = 2'd0;
            end else begin
                ra    = 7'($urandom_range(0, 7));
                rd    = $urandom;
                rop   = 2'($urandom_range(0, 3));
                rcode = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                dm_resp_code = rcode;
                if (m_err == 2'd0 && (rop == 2'd1 || rop == 2'd2))
                    exp_req.push_back({ra, (rop == 2'd2) ? rd : m_data, rop});
                scan(0, 1, dmi_word(ra, rd, rop), 41, dout);
                check("rnd_dmi_capture", dout, dmi_word(m_addr, m_data, m_err));
                if (m_err == 2'd0) begin
                    m_addr = ra;
                    if (rop == 2'd2) m_data = rd;
                    if (rop == 2'd1) m_data = dm_mem[ra];
                    if ((rop == 2'd1 || rop == 2'd2) && rcode != 2'd0) m_err = 2'd2;
                end
            end
            repeat (16) tick();
            check("rnd_idle", {dmi_req_valid_o, dmi_resp_ready_o}, 0);
            check("rnd_req_drained", exp_req.size(), 0);
            exp_req.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmi_dr_ctrl.md
# dmi_dr_ctrl

Data-register controller behind the FPGA-native JTAG TAP: sits between the TAP's capture/shift/update strobes and the Debug Module's DMI request/response port. Implements the `dtmcs` and `dmi` data registers, with capture, shift and update handling. Converts each DMI update into one DM request and returns the response through the next DMI capture. Tracks sticky `dmistat` errors and handles `dmireset`/`dmihardreset`. Everything runs in the TCK domain; DM-side CDC lives elsewhere.

## Interface
- ABITS, 7: DMI address width; DMI DR width is W = ABITS+34.
- IDLE, 1: value reported in `dtmcs.idle`.
- tck_i  in  1  TAP clock (from TAP `tck_o`); sole clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- dmi_clear_i  in  1  TAP test-logic-reset; synchronous clear identical to rst_i.
- capture_i / shift_i / update_i  in  1 each  TAP DR strobes.
- tdi_i  in  1  serial data in.
- dtmcs_select_i  in  1  dtmcs DR selected.
- dtmcs_tdo_o  out  1  dtmcs serial out.
- dmi_select_i  in  1  dmi DR selected.
- dmi_tdo_o  out  1  dmi serial out.
- dmi_req_valid_o  out  1; dmi_req_ready_i  in  1.
- dmi_req_addr_o  out  ABITS; dmi_req_op_o  out  2 (1 read, 2 write); dmi_req_data_o  out  32.
- dmi_resp_valid_i  in  1; dmi_resp_ready_o  out  1; dmi_resp_data_i  in  32; dmi_resp_resp_i  in  2 (0 = ok).
- dmi_hardreset_o  out  1  one-cycle pulse on dmihardreset.

## Operation
- State machine: IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE.
  - IDLE: no request in flight.
  - READ / WRITE: dmi_req_valid_o=1; on dmi_req_ready_i go to WAIT_READ / WAIT_WRITE.
  - WAIT_*: dmi_resp_ready_o=1; on dmi_resp_valid_i latch data_q<=dmi_resp_data_i (read only), then go to IDLE.
  - If dmi_resp_resp_i!=0 in a WAIT_* state: error_q<=2 (failed).
- dtmcs value: {14'b0, 1'b0 (dmihardreset), 1'b0 (dmireset), 1'b0, IDLE[2:0], error_q[1:0], ABITS[5:0], 4'd1}.
- dtmcs DR, when dtmcs_select_i:
  - capture loads the dtmcs value.
  - shift does sr<={tdi_i, sr[31:1]}.
  - update acts on sr[16]: error_q<=0.
  - update acts on sr[17]: error_q<=0, state<=IDLE (in-flight request abandoned, valid/ready drop next cycle), dmi_hardreset_o pulses.
- dmi DR, when dmi_select_i and not dtmcs_select_i:
  - capture loads {addr_q, data_q, error_q}. If state!=IDLE at capture: error_q<=3 (busy), loaded op field is 3.
  - shift does {tdi_i, dr[W-1:1]}.
  - update with state!=IDLE: error_q<=3, no request issued.
  - update with error_q!=0: ignored.
  - update otherwise: addr_q<=dr[W-1:34], op field dr[1:0].
    - op 1: state<=READ.
    - op 2: data_q<=dr[33:2], state<=WRITE.
    - op 0 or 3: no request.
- dmi_req_addr_o=addr_q, dmi_req_data_o=data_q, dmi_req_op_o=1 in READ and 2 in WRITE, 0 otherwise.
- Both selects high: dtmcs wins, dmi register untouched.
- error_q sticky: cleared only by dmireset, dmihardreset, rst_i, dmi_clear_i.
- Busy (3) overwrites failed (2); failed never overwrites busy, because error_q is only set to 2 when it is 0.

## Timing
- All registers update on tck_i rising edge.
- Reset (rst_i or dmi_clear_i): state IDLE, error_q 0, addr_q 0, data_q 0, both shift registers 0. Outputs dmi_req_valid_o 0, dmi_resp_ready_o 0, dmi_hardreset_o 0, both tdo 0. Reset mid-transaction abandons the request the next cycle.
- tdo outputs are combinational from the shift register LSB.
- One bit shifted per cycle while shift_i & select.
- Update to dmi_req_valid_o=1: 1 cycle. valid is held until ready; addr/op/data are stable while valid.
- Handshakes:
  - request completes in the cycle valid&ready.
  - response completes in the cycle valid&ready; data_q is visible to a capture from the next cycle.
- Minimum update-to-update for back-to-back reads with zero-latency DM: 3 cycles.
- Same-cycle capture and update never occur: the TAP guarantees exclusivity. If they do occur, update has priority.

## Test plan
- Reset, capture dtmcs, shift 32 bits -> dtmcs_tdo_o serialises 0x00001071 (ABITS=7, IDLE=1, version 1), LSB first.
- DMI write addr 0x10, data 0xDEADBEEF, op 2 -> next cycle req_valid=1, addr=0x10, op=2, data=0xDEADBEEF. Hold ready low 5 cycles, then valid stays; on ready, resp ok -> IDLE.
- DMI read addr 0x11 -> DM returns 0x12345678 resp 0. Next capture shifts out {0x11, 0x12345678, 2'b00}.
- Update with read while in WAIT_READ (resp delayed) -> no second request, captured op field 3. Subsequent update with op 1 is ignored. dtmcs update with bit16=1 -> dmistat 0, next read issues.
- DM returns resp 2 on read -> dmistat reads 2 via dtmcs, further DMI ops are ignored until dmireset.
- dtmcs update with bit17=1 during WAIT_WRITE -> dmi_hardreset_o pulses 1 cycle, valid/ready 0 next cycle, state IDLE, dmistat 0. rst_i mid-read gives the same outputs.
